// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, issue-queue FSM states and the queued entry layout.
package mdu_pkg;

   localparam int MDU_OPW   = 4;
   localparam int MDU_WIDTH = 32;

   typedef enum logic [MDU_OPW-1:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MADD  = 4'd5,
      MDU_MADDU = 4'd6,
      MDU_MSUB  = 4'd7,
      MDU_MSUBU = 4'd8
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } mdu_state_e;

   typedef struct packed {
      logic [MDU_OPW-1:0]   op;
      logic [MDU_WIDTH-1:0] a;
      logic [MDU_WIDTH-1:0] b;
   } mdu_entry_t;

endpackage

// File: rtl/mdu_req_fifo.sv
// Synchronous request FIFO with async active-low reset and a synchronous clear that beats push/pop.
module mdu_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 68
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         wr_en,
   input  logic [W-1:0]                 wr_data,
   input  logic                         rd_en,
   output logic [W-1:0]                 rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !clear) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/mdu_issue_queue.sv
// EX-stage issue queue in front of the MDU: buffers ops, issues one at a time, stalls HI/LO access, aborts on flush.
// Optional MDU_ISSUE_BYPASS_EN: an op arriving at an idle, empty queue skips the FIFO write.
module mdu_issue_queue
   import mdu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         req_valid,
   input  logic [OPW-1:0]               req_op,
   input  logic [WIDTH-1:0]             req_a,
   input  logic [WIDTH-1:0]             req_b,
   output logic                         req_ready,
   input  logic                         hilo_acc,
   output logic                         stall,
   input  logic                         mdu_busy,
   output logic [OPW-1:0]               mdu_op,
   output logic [WIDTH-1:0]             mdu_a,
   output logic [WIDTH-1:0]             mdu_b,
   output logic                         mdu_clr,
   output logic [$clog2(DEPTH+1)-1:0]   q_count,
   output logic [1:0]                   state_dbg
);

   localparam int W = OPW + 2*WIDTH;

   mdu_state_e state;
   mdu_state_e state_nxt;
   logic [W-1:0] head;
   logic [W-1:0] req_ent;
   logic [W-1:0] issue_ent;
   logic         full;
   logic         empty;
   logic         push_ok;
   logic         bypass;
   logic         wr_en;
   logic         rd_en;

   assign req_ent   = {req_op, req_a, req_b};
   assign req_ready = !full;
   assign push_ok   = req_valid && req_ready && (req_op != '0) && !flush;

`ifdef MDU_ISSUE_BYPASS_EN
   assign bypass = push_ok && (state == IDLE) && empty && !mdu_busy;
`else
   assign bypass = 1'b0;
`endif

   assign wr_en = push_ok && !bypass;
   // A bypassed op never enters the FIFO, so an empty FIFO in ISSUE means nothing to pop.
   assign rd_en = (state == ISSUE) && !empty;

   mdu_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .wr_en   (wr_en),
      .wr_data (req_ent),
      .rd_en   (rd_en),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (q_count)
   );

   // An op pushed into an idle, empty queue issues in the very next cycle.
   always_comb begin
      state_nxt = state;
      issue_ent = head;
      case (state)
         IDLE: begin
            if (empty) issue_ent = req_ent;
            if (!mdu_busy && (!empty || push_ok)) state_nxt = ISSUE;
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (!mdu_busy) state_nxt = empty ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         mdu_op  <= '0;
         mdu_a   <= '0;
         mdu_b   <= '0;
         mdu_clr <= 1'b0;
      end else begin
         state   <= state_nxt;
         mdu_clr <= flush && (state != IDLE);
         if (state_nxt == ISSUE) {mdu_op, mdu_a, mdu_b} <= issue_ent;
         else                    {mdu_op, mdu_a, mdu_b} <= '0;
      end
   end

   assign stall = (hilo_acc && ((q_count != '0) || (state != IDLE) || mdu_busy))
                || (req_valid && !req_ready);

   assign state_dbg = state;

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Bench for mdu_issue_queue: randomized ops against a queue-level reference model and a simple MDU model.
module tb_mdu_issue_queue;
   import mdu_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int OPW   = 4;
   localparam int W     = OPW + 2*WIDTH;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             req_valid = 1'b0;
   logic [OPW-1:0]   req_op = '0;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic             hilo_acc = 1'b0;
   logic             mdu_busy = 1'b0;
   logic             req_ready;
   logic             stall;
   logic [OPW-1:0]   mdu_op;
   logic [WIDTH-1:0] mdu_a;
   logic [WIDTH-1:0] mdu_b;
   logic             mdu_clr;
   logic [CW-1:0]    q_count;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   mdu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OPW(OPW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .hilo_acc  (hilo_acc),
      .stall     (stall),
      .mdu_busy  (mdu_busy),
      .mdu_op    (mdu_op),
      .mdu_a     (mdu_a),
      .mdu_b     (mdu_b),
      .mdu_clr   (mdu_clr),
      .q_count   (q_count),
      .state_dbg (state_dbg)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: ops accepted but not yet issued, in program order.
   logic [W-1:0] exp_q[$];
   bit m_issuing;
   bit m_waiting;
   bit m_clr;
   int busy_left;
   int lat_lo = 1;
   int lat_hi = 4;
   bit last_issue;
   bit last_flush;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Monitor: every issued op must be the oldest outstanding one.
   always @(negedge clk) begin
      if (reset && mdu_op != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected got=%0h want=none", {mdu_op, mdu_a, mdu_b});
         end else begin
            chk("issue_entry", {mdu_op, mdu_a, mdu_b}, exp_q.pop_front());
         end
      end
   end

   task automatic step(input bit v, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit hilo, input bit fl);
      int cnt;
      int qn;
      bit rdy;
      bit push_acc;
      bit nxt_issue;
      @(negedge clk);
      if (last_flush)      busy_left = 0;
      else if (last_issue) busy_left = $urandom_range(lat_hi, lat_lo);
      mdu_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      req_valid = v; req_op = op; req_a = a; req_b = b; hilo_acc = hilo; flush = fl;
      #1;
      cnt = exp_q.size() + (m_issuing ? 1 : 0);
      rdy = (cnt < DEPTH);
      chk("issue_now", W'(mdu_op != '0), W'(m_issuing));
      chk("mdu_clr",   W'(mdu_clr),      W'(m_clr));
      chk("q_count",   W'(q_count),      W'(cnt));
      chk("req_ready", W'(req_ready),    W'(rdy));
      chk("stall",     W'(stall),
          W'((hilo && (cnt > 0 || m_issuing || m_waiting || mdu_busy)) || (v && !rdy)));
      last_issue = (mdu_op != '0);
      last_flush = fl;
      push_acc   = v && (op != '0) && rdy && !fl;
      qn         = exp_q.size();
      @(posedge clk);
      if (fl) begin
         m_clr     = m_issuing || m_waiting;
         m_issuing = 1'b0;
         m_waiting = 1'b0;
         exp_q.delete();
      end else begin
         m_clr     = 1'b0;
         nxt_issue = 1'b0;
         if (m_issuing) m_waiting = 1'b1;
         else if (m_waiting) begin
            if (!mdu_busy) begin
               m_waiting = 1'b0;
               nxt_issue = (qn > 0);
            end
         end else nxt_issue = !mdu_busy && (qn > 0 || push_acc);
         m_issuing = nxt_issue;
         if (nxt_issue) m_waiting = 1'b0;
         if (push_acc) exp_q.push_back({op, a, b});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic reset_checks();
      chk("rst_mdu_op",    W'(mdu_op),    '0);
      chk("rst_mdu_a",     W'(mdu_a),     '0);
      chk("rst_mdu_b",     W'(mdu_b),     '0);
      chk("rst_mdu_clr",   W'(mdu_clr),   '0);
      chk("rst_q_count",   W'(q_count),   '0);
      chk("rst_req_ready", W'(req_ready), W'(1'b1));
      chk("rst_stall",     W'(stall),     '0);
   endtask

   task automatic do_reset_mid();
      @(negedge clk);
      #2;
      req_valid = 1'b0; hilo_acc = 1'b0; flush = 1'b0; mdu_busy = 1'b0;
      reset = 1'b0;
      #1;
      reset_checks();
      exp_q.delete();
      m_issuing = 1'b0; m_waiting = 1'b0; m_clr = 1'b0;
      busy_left = 0; last_issue = 1'b0; last_flush = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_checks();
      reset = 1'b1;

      // Single MULT with a negative operand, then drain.
      lat_lo = 3; lat_hi = 3;
      step(1'b1, MDU_MULT, 32'd7, 32'(-3), 1'b0, 1'b0);
      idle(8);

      // MFHI right behind a MULT.
      step(1'b1, MDU_MULT, 32'd5, 32'd6, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

      // Long MULTU, fill the queue with DIVs, then hammer the full queue.
      lat_lo = 8; lat_hi = 8;
      step(1'b1, MDU_MULTU, 32'd1, 32'd2, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 4; i++) step(1'b1, MDU_DIV, 32'(100 + i), 32'd3, 1'b0, 1'b0);
      step(1'b1, MDU_DIVU, 32'd9, 32'd9, 1'b0, 1'b0);
      step(1'b1, MDU_DIVU, 32'd9, 32'd9, 1'b1, 1'b0);
      idle(60);

      // Flush while waiting on the MDU with two ops queued.
      step(1'b1, MDU_MULT, 32'd11, 32'd12, 1'b0, 1'b0);
      idle(1);
      step(1'b1, MDU_DIV, 32'd13, 32'd14, 1'b0, 1'b0);
      step(1'b1, MDU_DIV, 32'd15, 32'd16, 1'b0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b0, 1'b1);
      idle(15);

      // Flush and push together in IDLE.
      step(1'b1, MDU_MADD, 32'd3, 32'd4, 1'b0, 1'b1);
      idle(5);

      // Reset mid-operation.
      lat_lo = 4; lat_hi = 4;
      step(1'b1, MDU_MSUB, 32'd21, 32'd22, 1'b0, 1'b0);
      step(1'b1, MDU_DIVU, 32'd23, 32'd24, 1'b0, 1'b0);
      idle(1);
      do_reset_mid();
      idle(3);

      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(3, 0) != 0, OPW'($urandom_range(8, 0)), $urandom, $urandom,
              $urandom_range(5, 0) == 0, $urandom_range(49, 0) == 0);
      end
      idle(40);
      chk("drain_empty", W'(exp_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
